// File: rtl/dsa_pkg.sv
// Shared types and constants for the DSA job controller.
package dsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    VALID,
    LAUNCH,
    WAIT_BUSY,
    RUN,
    ABORT
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_DIM  = 2'd1,
    ERR_OVF  = 2'd2,
    ERR_TMO  = 2'd3
  } err_e;

  // Cycles the core gets to raise busy after a launch before the job is aborted.
  localparam int WAIT_BUSY_LIMIT = 8;

endpackage

// File: rtl/dsa_cfg_check.sv
// Configuration checker: registers the scaled output size during CHECK and
// classifies the shadowed job configuration while the controller is in VALID.
module dsa_cfg_check
  import dsa_pkg::*;
#(
  parameter int AW      = 12,
  parameter int MAX_DIM = 64
) (
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] in_w,
  input  logic [15:0] in_h,
  input  logic [15:0] scale_q88,
  output err_e        err
);

  localparam logic [15:0] MAX_D    = 16'(MAX_DIM);
  localparam logic [47:0] MAX_AREA = 48'd1 << AW;

  logic [23:0] out_w;
  logic [23:0] out_h;
  logic [47:0] area;

  // NOTE: sequential state is assigned with <= so every flop samples the pre-edge values.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      out_w <= '0;
      out_h <= '0;
    end else if (load) begin
      out_w <= 24'(({16'd0, in_w} * {16'd0, scale_q88}) >> 8);
      out_h <= 24'(({16'd0, in_h} * {16'd0, scale_q88}) >> 8);
    end
  end

  assign area = {24'd0, out_w} * {24'd0, out_h};

  // NOTE: err gets its default first so no path through this block can infer a latch.
  always_comb begin
    err = ERR_NONE;
    if (in_w < 16'd2 || in_w > MAX_D || in_h < 16'd2 || in_h > MAX_D || scale_q88 == '0)
      err = ERR_DIM;
    else if (out_w == '0 || out_h == '0 || area > MAX_AREA)
      err = ERR_OVF;
  end

endmodule

// File: rtl/dsa_job_ctrl.sv
// Job controller for the bilinear core: shadows and validates the configuration,
// launches the core, supervises it with a watchdog and gates JTAG image writes.
module dsa_job_ctrl
  import dsa_pkg::*;
#(
  parameter int AW      = 12,
  parameter int MAX_DIM = 64,
  parameter int WDOG_W  = 24
) (
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic        req_jtag,
  input  logic        req_sw,
  input  logic [15:0] cfg_in_w,
  input  logic [15:0] cfg_in_h,
  input  logic [15:0] cfg_scale_q88,
  output logic [15:0] core_in_w,
  output logic [15:0] core_in_h,
  output logic [15:0] core_scale_q88,
  output logic        core_start,
  output logic        core_srst,
  input  logic        core_busy,
  input  logic        core_done,
  input  logic        jtag_we_in,
  output logic        jtag_we_gated,
  output logic        st_busy,
  output logic        st_done,
  output logic [1:0]  st_err,
  output logic        pend_ovf,
  output logic [31:0] cycle_count,
  output logic [15:0] job_count,
  output logic [7:0]  wr_drop_cnt
);

  localparam logic [WDOG_W-1:0] WB_LAST   = WDOG_W'(WAIT_BUSY_LIMIT - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

  state_e            state, state_nx;
  err_e              chk_err, st_err_q;
  logic              req, pend, take;
  logic [WDOG_W-1:0] wdog;

  assign req  = req_jtag | req_sw;
  assign take = (state == IDLE) && (req || pend);

  dsa_cfg_check #(.AW(AW), .MAX_DIM(MAX_DIM)) u_check (
    .clk_50    (clk_50),
    .rst_n     (rst_n),
    .load      (state == CHECK),
    .in_w      (core_in_w),
    .in_h      (core_in_h),
    .scale_q88 (core_scale_q88),
    .err       (chk_err)
  );

  // wdog counts cycles spent in the current state; it serves WAIT_BUSY, RUN and ABORT.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (take) state_nx = CHECK;
      CHECK:     state_nx = VALID;
      VALID:     state_nx = (chk_err == ERR_NONE) ? LAUNCH : IDLE;
      LAUNCH:    state_nx = WAIT_BUSY;
      WAIT_BUSY: if (core_busy) state_nx = RUN;
                 else if (wdog == WB_LAST) state_nx = ABORT;
      RUN:       if (core_done) state_nx = IDLE;
                 else if (wdog == WDOG_LAST) state_nx = ABORT;
      ABORT:     if (wdog[0]) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wdog  <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state)  wdog <= '0;
      else if (state != IDLE) wdog <= wdog + 1'b1;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      core_in_w      <= '0;
      core_in_h      <= '0;
      core_scale_q88 <= '0;
      core_start     <= 1'b0;
      st_done        <= 1'b0;
      st_err_q       <= ERR_NONE;
      pend           <= 1'b0;
      pend_ovf       <= 1'b0;
      job_count      <= '0;
    end else begin
      core_start <= (state == VALID) && (chk_err == ERR_NONE);
      if (take) begin
        core_in_w      <= cfg_in_w;
        core_in_h      <= cfg_in_h;
        core_scale_q88 <= cfg_scale_q88;
        st_done        <= 1'b0;
        st_err_q       <= ERR_NONE;
        pend           <= 1'b0;
      end else if (req && state != IDLE) begin
        if (pend) pend_ovf <= 1'b1;
        else      pend     <= 1'b1;
      end
      if (state == VALID) st_err_q <= chk_err;
      if (state_nx == ABORT && state != ABORT) st_err_q <= ERR_TMO;
      if (state == RUN && core_done) begin
        st_done   <= 1'b1;
        job_count <= job_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
      wr_drop_cnt <= '0;
    end else begin
      // LAUNCH restarts the count and is itself the first counted cycle.
      if (state == LAUNCH) cycle_count <= 32'd1;
      else if (state == WAIT_BUSY || state == RUN) cycle_count <= cycle_count + 1'b1;
      if (jtag_we_in && state != IDLE && wr_drop_cnt != 8'hFF)
        wr_drop_cnt <= wr_drop_cnt + 1'b1;
    end
  end

  assign st_err        = st_err_q;
  assign st_busy       = (state != IDLE);
  assign core_srst     = (state == ABORT);
  assign jtag_we_gated = jtag_we_in && (state == IDLE);

endmodule

// File: tb/tb_dsa_job_ctrl.sv
// Self-checking bench for dsa_job_ctrl: a behavioural core model plus directed and
// randomized jobs compared against expectations derived from the job rules.
module tb_dsa_job_ctrl;

  localparam int AW       = 12;
  localparam int MAX_DIM  = 64;
  localparam int WDOG_W   = 13;
  localparam int WB_LIMIT = 8;

  logic        clk_50 = 1'b0;
  logic        rst_n;
  logic        req_jtag, req_sw;
  logic [15:0] cfg_in_w, cfg_in_h, cfg_scale_q88;
  logic [15:0] core_in_w, core_in_h, core_scale_q88;
  logic        core_start, core_srst;
  logic        core_busy, core_done;
  logic        jtag_we_in, jtag_we_gated;
  logic        st_busy, st_done, pend_ovf;
  logic [1:0]  st_err;
  logic [31:0] cycle_count;
  logic [15:0] job_count;
  logic [7:0]  wr_drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_jobs = 0;
  int exp_drop = 0;

  // core model controls (main block) and observations (model block)
  int m_run = 1;
  bit m_hang = 1'b0;
  bit m_nobusy = 1'b0;
  int stray_req = 0;
  int stray_ack = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  bit cm_on;
  int cm_left;

  dsa_job_ctrl #(.AW(AW), .MAX_DIM(MAX_DIM), .WDOG_W(WDOG_W)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .req_jtag(req_jtag), .req_sw(req_sw),
    .cfg_in_w(cfg_in_w), .cfg_in_h(cfg_in_h), .cfg_scale_q88(cfg_scale_q88),
    .core_in_w(core_in_w), .core_in_h(core_in_h), .core_scale_q88(core_scale_q88),
    .core_start(core_start), .core_srst(core_srst), .core_busy(core_busy), .core_done(core_done),
    .jtag_we_in(jtag_we_in), .jtag_we_gated(jtag_we_gated), .st_busy(st_busy), .st_done(st_done),
    .st_err(st_err), .pend_ovf(pend_ovf), .cycle_count(cycle_count), .job_count(job_count),
    .wr_drop_cnt(wr_drop_cnt)
  );

  always #10 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;

  // Core model: busy one cycle after start, done after m_run busy cycles.
  always @(negedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      core_busy = 1'b0;
      core_done = 1'b0;
      cm_on = 1'b0;
    end else begin
      core_done = 1'b0;
      if (stray_req != stray_ack) begin
        core_done = 1'b1;
        stray_ack = stray_req;
      end
      if (core_srst) begin
        core_busy = 1'b0;
        cm_on = 1'b0;
      end else if (core_start) begin
        cm_on = 1'b1;
        cm_left = m_run;
        start_cyc = cyc;
      end else if (cm_on) begin
        core_busy = !m_nobusy;
        if (!m_hang && cm_left == 0) begin
          core_done = 1'b1;
          core_busy = 1'b0;
          cm_on = 1'b0;
          done_cyc = cyc;
        end else if (cm_left > 0) begin
          cm_left--;
        end
      end
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL global_timeout: observed no finish, required finish within budget");
    $fatal(1, "bench timed out");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected error code straight from the job acceptance rules.
  function automatic int exp_err(input int w, input int h, input int s);
    longint ow, oh;
    if (w < 2 || w > MAX_DIM || h < 2 || h > MAX_DIM || s == 0) return 1;
    ow = (longint'(w) * longint'(s)) / 256;
    oh = (longint'(h) * longint'(s)) / 256;
    if (ow == 0 || oh == 0 || ow * oh > (longint'(1) << AW)) return 2;
    return 0;
  endfunction

  task automatic pulse_req(input int mode);
    req_jtag = (mode != 1);
    req_sw   = (mode != 0);
    tick();
    req_jtag = 1'b0;
    req_sw   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (st_busy && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_idle"}, 32'(st_busy), 0);
  endtask

  task automatic wait_start(output int l, input int budget, input string tag);
    int k = 0;
    while (!core_start && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_start"}, 32'(core_start), 1);
    l = cyc;
  endtask

  task automatic expect_abort(input int l, input int delay, input string tag);
    int k = 0;
    while (!core_srst && k < 20000) begin
      tick();
      k++;
    end
    check({tag, "_srst"}, 32'(core_srst), 1);
    check({tag, "_when"}, 32'(cyc - l), 32'(delay));
    tick();
    check({tag, "_srst2"}, 32'(core_srst), 1);
    tick();
    check({tag, "_srst_end"}, 32'(core_srst), 0);
    check({tag, "_busy"}, 32'(st_busy), 0);
    check({tag, "_err"}, 32'(st_err), 3);
  endtask

  task automatic run_job(input int w, input int h, input int s, input int run,
                         input string tag, input int mode);
    int e;
    e = exp_err(w, h, s);
    m_run = run;
    m_hang = 1'b0;
    m_nobusy = 1'b0;
    cfg_in_w = 16'(w);
    cfg_in_h = 16'(h);
    cfg_scale_q88 = 16'(s);
    pulse_req(mode);
    cfg_in_w = 16'($urandom);
    cfg_scale_q88 = 16'($urandom);
    check({tag, "_busy"}, 32'(st_busy), 1);
    check({tag, "_shadow_w"}, 32'(core_in_w), 32'(w));
    tick();
    check({tag, "_nostart"}, 32'(core_start), 0);
    tick();
    if (e == 0) begin
      check({tag, "_start"}, 32'(core_start), 1);
      wait_idle(run + 20, tag);
      exp_jobs++;
      check({tag, "_done"}, 32'(st_done), 1);
      check({tag, "_jobs"}, 32'(job_count), 32'(exp_jobs));
      check({tag, "_cycles"}, cycle_count, 32'(done_cyc - start_cyc + 1));
    end else begin
      check({tag, "_start"}, 32'(core_start), 0);
      check({tag, "_busy_err"}, 32'(st_busy), 0);
      check({tag, "_done"}, 32'(st_done), 0);
    end
    check({tag, "_err"}, 32'(st_err), 32'(e));
    check({tag, "_shadow_s"}, 32'(core_scale_q88), 32'(s));
  endtask

  initial begin
    int la, lb, lc, l, seen;
    rst_n = 1'b0;
    req_jtag = 1'b0;
    req_sw = 1'b0;
    cfg_in_w = '0;
    cfg_in_h = '0;
    cfg_scale_q88 = '0;
    jtag_we_in = 1'b0;
    tick(3);
    check("rst_busy", 32'(st_busy), 0);
    check("rst_start", 32'(core_start), 0);
    check("rst_srst", 32'(core_srst), 0);
    check("rst_flags", {29'd0, st_done, st_err}, 0);
    check("rst_cycles", cycle_count, 0);
    check("rst_jobs", 32'(job_count), 0);
    rst_n = 1'b1;
    tick(2);

    jtag_we_in = 1'b1;
    #1 check("we_idle_pass", 32'(jtag_we_gated), 1);
    tick();
    jtag_we_in = 1'b0;
    check("we_idle_nodrop", 32'(wr_drop_cnt), 0);

    run_job(64, 64, 16'h0100, 4096, "big", 0);
    run_job(1, 64, 16'h0100, 1, "w1", 0);
    run_job(64, 64, 16'h0200, 1, "area", 0);
    run_job(2, 2, 16'h0100, 3, "min", 1);
    run_job(65, 8, 16'h0100, 1, "w65", 0);
    run_job(8, 8, 0, 1, "s0", 0);
    run_job(64, 64, 1, 1, "out0", 0);
    run_job(64, 64, 16'h0101, 5, "both", 2);
    tick(6);
    check("both_single_busy", 32'(st_busy), 0);
    check("both_single_jobs", 32'(job_count), 32'(exp_jobs));

    stray_req++;
    tick(4);
    check("stray_done_jobs", 32'(job_count), 32'(exp_jobs));

    // pending slot, overflow, re-shadow and request coinciding with done
    m_run = 40;
    cfg_in_w = 16'd16;
    cfg_in_h = 16'd16;
    cfg_scale_q88 = 16'h0100;
    pulse_req(0);
    wait_start(la, 8, "pa");
    while (cyc < la + 5) tick();
    pulse_req(1);
    check("pend_ovf_one", 32'(pend_ovf), 0);
    while (cyc < la + 8) tick();
    cfg_in_w = 16'd32;
    cfg_scale_q88 = 16'h0180;
    pulse_req(0);
    check("pend_ovf_two", 32'(pend_ovf), 1);
    m_run = 20;
    wait_idle(60, "pa");
    exp_jobs++;
    check("pa_done", 32'(st_done), 1);
    wait_start(lb, 10, "pb");
    check("pb_delay", 32'(lb - la), 32'(1 + 40 + 4));
    check("pb_reshadow", 32'(core_in_w), 32);
    tick();
    m_run = 10;
    while (cyc < lb + 1 + 20) tick();
    pulse_req(0);
    exp_jobs++;
    wait_start(lc, 10, "pc");
    check("pc_delay", 32'(lc - lb), 32'(1 + 20 + 4));
    wait_idle(40, "pc");
    exp_jobs++;
    tick(8);
    check("pend_quiet_busy", 32'(st_busy), 0);
    check("pend_jobs", 32'(job_count), 32'(exp_jobs));

    // JTAG write gating during a long job
    m_run = 400;
    pulse_req(0);
    wait_start(l, 8, "wg");
    tick(2);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      jtag_we_in = 1'b1;
      #1 if (jtag_we_gated) seen++;
      tick();
    end
    jtag_we_in = 1'b0;
    exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
    check("we_gated_run", 32'(seen), 0);
    check("wr_drop_sat", 32'(wr_drop_cnt), 32'(exp_drop));
    wait_idle(200, "wg");
    exp_jobs++;
    check("wg_jobs", 32'(job_count), 32'(exp_jobs));
    jtag_we_in = 1'b1;
    #1 check("we_idle_again", 32'(jtag_we_gated), 1);
    tick();
    jtag_we_in = 1'b0;
    check("wr_drop_hold", 32'(wr_drop_cnt), 32'(exp_drop));

    // randomized configurations
    for (int i = 0; i < 16; i++) begin
      int w, h, s, sel;
      w = int'($urandom_range(0, 70));
      h = int'($urandom_range(0, 70));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       s = 0;
        1:       s = int'($urandom_range(1, 16'h40));
        2:       s = 16'h0100;
        default: s = int'($urandom_range(16'h80, 16'h300));
      endcase
      run_job(w, h, s, int'($urandom_range(1, 30)), $sformatf("rnd%0d", i),
              int'($urandom_range(0, 2)));
    end

    // core never raises busy, then core never finishes
    m_hang = 1'b1;
    m_nobusy = 1'b1;
    cfg_in_w = 16'd8;
    cfg_in_h = 16'd8;
    cfg_scale_q88 = 16'h0100;
    pulse_req(0);
    wait_start(l, 8, "wb");
    expect_abort(l, 1 + WB_LIMIT, "wb_abort");
    m_nobusy = 1'b0;
    pulse_req(1);
    wait_start(l, 8, "wd");
    expect_abort(l, 2 + (1 << WDOG_W) - 1, "wd_abort");
    check("wd_done", 32'(st_done), 0);
    check("wd_jobs", 32'(job_count), 32'(exp_jobs));
    m_hang = 1'b0;

    // asynchronous reset in the middle of a job
    m_run = 200;
    pulse_req(0);
    wait_start(l, 8, "rr");
    tick(20);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(st_busy), 0);
    check("mid_rst_srst", 32'(core_srst), 0);
    check("mid_rst_counts", {job_count, wr_drop_cnt, 7'd0, pend_ovf}, 0);
    check("mid_rst_cycles", cycle_count, 0);
    check("mid_rst_shadow", 32'(core_in_w), 0);
    tick(2);
    rst_n = 1'b1;
    exp_jobs = 0;
    exp_drop = 0;
    tick();
    run_job(10, 12, 16'h0180, 15, "after_rst", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
